// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared memory-map constants, STATUS layout and address decode
package data_mem_responder_pkg;

    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0008;

    localparam int STAT_FULL_BIT    = 0;
    localparam int STAT_EMPTY_BIT   = 1;
    localparam int STAT_COUNT_LSB   = 4;
    localparam int STAT_COUNT_W     = 4;
    localparam int STAT_OVF_BIT     = 8;
    localparam int STAT_BADADDR_BIT = 9;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_CYCLE,
        REGION_TXDATA,
        REGION_STATUS,
        REGION_BAD
    } region_e;

    // Word-granular decode: the two byte-offset bits never take part.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_words);
        region_e region;
        if ({2'b00, addr[31:2]} < ram_words) begin
            region = REGION_RAM;
        end else if (addr[31:2] == ADDR_CYCLE[31:2]) begin
            region = REGION_CYCLE;
        end else if (addr[31:2] == ADDR_TXDATA[31:2]) begin
            region = REGION_TXDATA;
        end else if (addr[31:2] == ADDR_STATUS[31:2]) begin
            region = REGION_STATUS;
        end else begin
            region = REGION_BAD;
        end
        return region;
    endfunction

    function automatic logic [31:0] pack_status(input logic       full,
                                                input logic       empty,
                                                input logic [3:0] count,
                                                input logic       ovf,
                                                input logic       badaddr);
        logic [31:0] s;
        s = '0;
        s[STAT_FULL_BIT]                    = full;
        s[STAT_EMPTY_BIT]                   = empty;
        s[STAT_COUNT_LSB +: STAT_COUNT_W]   = count;
        s[STAT_OVF_BIT]                     = ovf;
        s[STAT_BADADDR_BIT]                 = badaddr;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// rtl/data_mem_responder_tx_fifo.sv - TX byte FIFO with same-cycle push/pop on full
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // An empty FIFO never pops; a full one still takes a push when a pop frees a slot.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-side RAM, free-running cycle counter and TX byte port
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_cycle;
    logic              r_ovf;
    logic              r_badaddr;

    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_cycle_next;
    logic              w_push;
    logic              w_pop;
    logic              w_push_drop;
    logic              w_status_wr;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [3:0]        w_status_count;
    logic [7:0]        w_head;
    logic              w_unused_addr_lsb;

    assign w_region          = decode_region(addr, 32'(RAM_WORDS));
    assign w_ram_idx         = addr[RAM_AW+1:2];
    assign w_unused_addr_lsb = ^addr[1:0];
    assign w_cycle_next      = r_cycle + 32'd1;

    assign w_pop       = tx_ready && !w_empty;
    assign w_push      = we && (w_region == REGION_TXDATA);
    assign w_push_drop = w_push && w_full && !w_pop;
    assign w_status_wr = we && (w_region == REGION_STATUS);

    assign tx_valid = !w_empty;
    assign tx_data  = w_head;

    if (CNT_W >= STAT_COUNT_W) begin : g_cnt_trunc
        assign w_status_count = w_count[STAT_COUNT_W-1:0];
    end else begin : g_cnt_ext
        assign w_status_count = {{(STAT_COUNT_W-CNT_W){1'b0}}, w_count};
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (wdata[7:0]),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // RAM survives reset; only a write outside reset lands.
    always_ff @(posedge clk) begin
        if (!rst && we && (w_region == REGION_RAM)) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            r_ovf     <= 1'b0;
            r_badaddr <= 1'b0;
        end else begin
            r_cycle   <= (we && (w_region == REGION_CYCLE)) ? 32'd0 : w_cycle_next;
            // Sticky flags: a new event outranks a W1C clear in the same cycle.
            r_ovf     <= w_push_drop ||
                         (r_ovf && !(w_status_wr && wdata[STAT_OVF_BIT]));
            r_badaddr <= (w_region == REGION_BAD) ||
                         (r_badaddr && !(w_status_wr && wdata[STAT_BADADDR_BIT]));
        end
    end

    always_comb begin
        rdata = '0;
        case (w_region)
            REGION_RAM:    rdata = r_ram[w_ram_idx];
            REGION_CYCLE:  rdata = r_cycle;
            REGION_STATUS: rdata = pack_status(w_full, w_empty, w_status_count,
                                               r_ovf, r_badaddr);
            default:       rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks against a behavioural model
module tb_data_mem_responder;

    localparam int RW    = 256;
    localparam int RW_AW = 8;
    localparam int FD    = 8;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam int W_CYCLE  = 32'h3FFF_C000;
    localparam int W_TXDATA = 32'h3FFF_C001;
    localparam int W_STATUS = 32'h3FFF_C002;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_q[$];
    logic [31:0] m_cycle;
    bit          m_ovf;
    bit          m_bad;
    bit          m_valid = 1'b0;
    logic [31:0] m_ram [RW];
    bit          m_known [RW];
    bit          force_cycle = 1'b0;

    data_mem_responder #(
        .RAM_WORDS  (RW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = m_q.size();
        return 32'((n == FD ? 1 : 0) + (n == 0 ? 2 : 0) + 16 * (n % 16) +
                   256 * int'(m_ovf) + 512 * int'(m_bad));
    endfunction

    // Compare, then advance the model by one clock edge.
    always @(negedge clk) begin
        int          widx;
        bit          exp_chk;
        logic [31:0] exp_rdata;
        bit          is_pop, is_push, was_full, st_wr, unmapped;
        widx = int'(addr[31:2]);
        unmapped = (widx >= RW) && (widx != W_CYCLE) && (widx != W_TXDATA) && (widx != W_STATUS);
        if (m_valid) begin
            exp_chk   = 1'b1;
            exp_rdata = 32'd0;
            if (widx < RW) begin
                exp_chk   = m_known[widx[RW_AW-1:0]];
                exp_rdata = m_ram[widx[RW_AW-1:0]];
            end else if (widx == W_CYCLE) begin
                exp_rdata = m_cycle;
            end else if (widx == W_STATUS) begin
                exp_rdata = model_status();
            end
            if (exp_chk) check("rdata", rdata, exp_rdata);
            check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
        end
        if (!rst && we && widx < RW) begin
            m_ram[widx[RW_AW-1:0]]   = wdata;
            m_known[widx[RW_AW-1:0]] = 1'b1;
        end
        if (rst) begin
            m_q.delete();
            m_cycle = 32'd0;
            m_ovf   = 1'b0;
            m_bad   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            is_pop   = (m_q.size() != 0) && tx_ready;
            is_push  = we && (widx == W_TXDATA);
            was_full = (m_q.size() == FD);
            st_wr    = we && (widx == W_STATUS);
            if (is_pop) void'(m_q.pop_front());
            if (is_push && (!was_full || is_pop)) m_q.push_back(wdata[7:0]);
            m_ovf = (is_push && was_full && !is_pop) || (m_ovf && !(st_wr && wdata[8]));
            m_bad = unmapped || (m_bad && !(st_wr && wdata[9]));
            if (force_cycle)                   m_cycle = 32'hFFFF_FFFF;
            else if (we && widx == W_CYCLE)    m_cycle = 32'd0;
            else                               m_cycle = m_cycle + 32'd1;
        end
    end

    // Drive one cycle's inputs just after the edge; return at the following negedge.
    task automatic cyc(input bit rs, input logic [31:0] a, input logic [31:0] d,
                       input bit w, input bit r);
        @(posedge clk);
        #1;
        rst = rs; addr = a; wdata = d; we = w; tx_ready = r;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            4:          a = ($urandom_range(0, RW - 1) << 2) | $urandom_range(0, 3);
            5:          a = A_CYCLE | $urandom_range(0, 3);
            6, 7:       a = A_TXDATA;
            8:          a = A_STATUS | $urandom_range(0, 3);
            default: begin
                case ($urandom_range(0, 3))
                    0:       a = 32'(RW * 4) + ($urandom_range(0, 100) << 2);
                    1:       a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
                    2:       a = 32'hFFFF_000C;
                    default: a = 32'hFFFE_FFFC;
                endcase
            end
        endcase
        return a;
    endfunction

    logic [7:0] exp_bytes [8];

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; tx_ready = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        cyc(0, A_STATUS, 0, 0, 0);
        check("reset_status", rdata, 32'h0000_0002);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        cyc(0, A_CYCLE, 0, 0, 0);
        check("cycle_after_reset", rdata, 32'd1);

        cyc(0, 32'h10, 32'hDEAD_BEEF, 1, 0);
        cyc(0, 32'h10, 0, 0, 0);
        check("ram_readback", rdata, 32'hDEAD_BEEF);
        cyc(0, 32'h14, 0, 0, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("no_badaddr", rdata, 32'h0000_0002);

        for (int i = 1; i <= 9; i++) cyc(0, A_TXDATA, 32'(i), 1, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("full_ovf_status", rdata, 32'h0000_0181);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 32'h0, 0, 0, 1);
            check("drain_order", 32'(tx_data), 32'(i));
        end
        cyc(0, A_STATUS, 0, 0, 0);
        check("drained_status", rdata, 32'h0000_0102);
        cyc(0, A_STATUS, 32'h100, 1, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("ovf_cleared", rdata, 32'h0000_0002);

        for (int i = 0; i < 8; i++) cyc(0, A_TXDATA, 32'h11 + 32'(i), 1, 0);
        cyc(0, A_TXDATA, 32'hAA, 1, 1);
        check("push_pop_full_head", 32'(tx_data), 32'h11);
        cyc(0, A_STATUS, 0, 0, 0);
        check("push_pop_full_status", rdata, 32'h0000_0081);
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h12 + 8'(i);
        exp_bytes[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 32'h0, 0, 0, 1);
            check("push_pop_drain", 32'(tx_data), 32'(exp_bytes[i]));
        end

        cyc(0, A_CYCLE, 32'h1234, 1, 0);
        cyc(0, A_CYCLE, 0, 0, 0);
        check("cycle_cleared", rdata, 32'd0);
        cyc(0, A_CYCLE, 0, 0, 0);
        check("cycle_next", rdata, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0; addr = A_CYCLE; we = 1'b0; tx_ready = 1'b0;
        force dut.w_cycle_next = 32'hFFFF_FFFF;
        force_cycle = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        release dut.w_cycle_next;
        force_cycle = 1'b0;
        @(negedge clk);
        check("cycle_max", rdata, 32'hFFFF_FFFF);
        cyc(0, A_CYCLE, 0, 0, 0);
        check("cycle_wrap", rdata, 32'd0);

        cyc(0, 32'h8000_0000, 0, 0, 0);
        check("unmapped_rdata", rdata, 32'd0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("badaddr_set", rdata, 32'h0000_0202);
        cyc(0, A_STATUS, 32'h200, 1, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("badaddr_cleared", rdata, 32'h0000_0002);
        cyc(0, 32'h0000_0400, 32'h55, 1, 0);
        check("boundary_rdata", rdata, 32'd0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("badaddr_again", rdata, 32'h0000_0202);
        cyc(0, A_STATUS, 32'h2FF, 1, 0);
        cyc(0, 32'h3FC, 0, 0, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("last_word_mapped", rdata, 32'h0000_0002);

        cyc(0, 32'h20, 32'hCAFE_F00D, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, A_TXDATA, 32'h31 + 32'(i), 1, 0);
        cyc(1, 32'h20, 32'h1111_1111, 1, 0);
        cyc(0, A_STATUS, 0, 0, 0);
        check("rst_status", rdata, 32'h0000_0002);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        cyc(0, 32'h20, 0, 0, 0);
        check("rst_keeps_ram", rdata, 32'hCAFE_F00D);

        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 199) == 0, rand_addr(), $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, number of 32-bit RAM words (power of two).
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr  input  32  CPU byte address; addr[1:0] ignored.
REQ-006 wdata  input  32  CPU write data.
REQ-007 we  input  1  CPU write enable; a write commits at the rising edge.
REQ-008 rdata  output  32  read data, combinational from addr and current state.
REQ-009 tx_data  output  8  byte at the TX FIFO head.
REQ-010 tx_valid  output  1  FIFO non-empty.
REQ-011 tx_ready  input  1  consumer accepts; pop when tx_valid and tx_ready.

Function
REQ-012 Map: 0x0000_0000 to RAM_WORDS*4-1 is RAM, index addr[log2(RAM_WORDS)+1:2].
REQ-013 Map: 0xFFFF_0000 is CYCLE, 0xFFFF_0004 is TXDATA, 0xFFFF_0008 is STATUS.
REQ-014 RAM read is combinational; RAM write stores wdata at the edge.
REQ-015 A RAM read in the cycle after a write to the same word returns the new data.
REQ-016 CYCLE is 32 bits, increments every cycle, and wraps from 0xFFFF_FFFF to 0.
REQ-017 Any write to CYCLE loads 0 at that edge; the following cycle reads 0 (not 1).
REQ-018 A write to TXDATA pushes wdata[7:0]; a read of TXDATA returns 0.
REQ-019 STATUS read: bit0 full, bit1 empty, bits[7:4] count, bit8 ovf, bit9 badaddr, others 0.
REQ-020 STATUS write is W1C: wdata[8]=1 clears ovf, wdata[9]=1 clears badaddr; other bits are ignored.
REQ-021 A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-022 A push to a full FIFO with no simultaneous pop is dropped and sets ovf.
REQ-023 Simultaneous push and pop on an empty FIFO: the pop does not occur, the push is accepted, and count becomes 1.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.
REQ-025 An access (read or write) to an unmapped address returns rdata 0, ignores any write, and sets badaddr.
REQ-026 If set and clear of the same sticky bit coincide, set wins.
REQ-027 STATUS reads reflect pre-edge state; updates are visible the next cycle.

Reset
REQ-028 rst clears CYCLE, FIFO pointers, count, ovf, and badaddr; tx_valid is 0 the next cycle.
REQ-029 rst does not clear RAM contents; a we asserted during rst has no effect.
REQ-030 Reset mid-transfer discards FIFO contents with no pop handshake.

Structure
REQ-031 Address-map constants and STATUS bit positions live in the shared memory-map parameter header used by the CPU.
REQ-032 The FIFO is a sub-module tx_fifo (push, pop, full, empty, count), instantiated once.
REQ-033 The RAM is an inferred array with no vendor primitive.

Verification
REQ-034 Write 0xDEADBEEF to 0x10, read 0x10 next cycle -> rdata 0xDEADBEEF; read 0x14 with no write issued -> no badaddr.
REQ-035 Hold tx_ready=0 and push 9 bytes 0x01..0x09 -> STATUS = full, count 8, ovf=1; drain -> bytes 0x01..0x08 in order.
REQ-036 FIFO full, tx_ready=1, push 0xAA in the same cycle -> count stays 8, ovf=0, and 0xAA is the last byte out.
REQ-037 Write CYCLE, then read twice -> 0 then 1; force CYCLE to 0xFFFF_FFFF -> it reads 0 the next cycle.
REQ-038 Read 0x8000_0000 -> rdata 0 and badaddr=1; write STATUS 0x200 -> badaddr=0; repeat the access in the clear cycle -> badaddr stays 1.
REQ-039 Push 3 bytes, assert rst for one cycle -> tx_valid=0, count 0, RAM word written before reset unchanged.
